hexdisp_mux: RTL
================

# hexdisp_mux

Parametrised multi-digit, time-multiplexed hex display driver. It scans DIGITS common-anode or common-cathode digits from one shared segment bus. Display values are double-buffered so a frame never shows a torn update. It sits between the CPU-side I/O register block and the board's seven-segment pins.

## Interface
- DIGITS, 4: number of digits; 1..8.
- CLK_DIV, 50000: clk cycles per digit slot; ≥2.
- ACTIVE_LOW, 1: 1 drives seg/dp/an low-true; 0 drives them high-true.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- value  in  4*DIGITS  nibble i at [4i+3:4i] is shown on digit i; digit 0 is least significant.
- dp_in  in  DIGITS  per-digit decimal point request.
- blank  in  DIGITS  per-digit forced blank.
- load  in  1  single-cycle strobe that captures value/dp_in/blank into the shadow buffer.
- pending  out  1  the shadow buffer holds data not yet shown.
- frame  out  1  one-cycle pulse at each frame wrap.
- seg  out  7  segments gfedcba.
- dp  out  1  decimal point.
- an  out  DIGITS  digit enables; one-hot when active.

## Operation
- **Prescaler.** Counts 0..CLK_DIV-1 and emits `tick` when it is at CLK_DIV-1, then wraps to 0.
- **Digit index.** `idx` advances on each `tick`, from DIGITS-1 back to 0. That wrap is the frame boundary.
- **Frame boundary.** On the wrap, if pending=1: active ← shadow and pending ← 0. frame pulses whenever the wrap occurs, whether or not a transfer happened.
- **load.** Writes the shadow buffer and sets pending=1. Repeated loads before a wrap overwrite the shadow; the latest value wins.
- **load on the wrap cycle.** The loaded data goes directly into active and pending ends at 0; it is shown from the new frame.
- **Decode.**
  - Segments come from the active nibble `active[idx]` via the package lookup; dp comes from the active dp bit.
  - When the digit's blank bit is set, all segments and dp are off.
- **Anti-ghosting.** During the cycle in which `tick` fires, all an are driven inactive.
- **Polarity.** Polarity is applied only at the output registers.
- **Lookup patterns (active-high gfedcba):**
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001

## Timing
- **Reset values.** prescaler=0, idx=0, active=0, shadow=0, pending=0, frame=0. seg, dp and an all inactive: with ACTIVE_LOW=1 that is 7'h7F, 1, and all ones.
- **Registered outputs.** seg, dp and an are registered, one cycle of latency from idx/active. The first clock after reset deasserts shows digit 0 = '0'.
- **Slot length.** Each digit is enabled for CLK_DIV-1 cycles, then dark for 1 cycle. Frame period = DIGITS*CLK_DIV cycles.
- **pending.** Rises the cycle after load and falls the cycle after the wrap.
- **frame.** Registered; high for the one cycle after the wrap edge.
- **Reset mid-frame.** Asynchronously returns all state to reset values; no partial transfer survives.
- **DIGITS=1.** Every tick is a wrap.

## Configuration
- **HEXDISP_LZB_EN defined:** leading-zero blanking.
  - A digit i>0 is blanked when active nibbles i..DIGITS-1 are all zero and its dp bit is clear.
  - Digit 0 is never blanked by this rule.
  - The blank mask is computed combinationally from active.
- **HEXDISP_LZB_EN undefined:** all zero nibbles display as '0'; only the blank input blanks a digit.

## Structure
- **hexdisp_pkg:**
  - SEG_LUT, a 16×7 constant in active-high gfedcba order;
  - `seg_decode(nibble)` function;
  - `idx_t` width constant `$clog2(DIGITS>1?DIGITS:2)`.
- **hexdisp_prescaler sub-module:** parameter CLK_DIV; ports clk, reset, tick. Reused later by the LED/buzzer drivers.
- **hexdisp_mux:** holds the buffers, idx, LZB logic and output registers.

## Test plan
Bench uses DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1.
- **Reset then release, no load** → the cycle after release: an=4'b1110, seg=~7'b0111111. The dark cycle occurs at each tick, and the frame pulses every 16 cycles.
- **Load value=16'h12A5, dp_in=4'b0100 mid-frame** → pending=1. The old digits finish the frame; after the wrap, digit0 seg=~1101101 (5), digit1 ~1110111 (A), digit2 ~1011011 (2) with dp=0 (active), digit3 ~0000110 (1).
- **Two loads, 16'h1111 then 16'h2222, before the wrap** → the next frame shows all '2'.
- **Load 16'hBEEF on the exact wrap cycle** → digit0 shows F in the same new frame, and pending stays 0.
- **With HEXDISP_LZB_EN, load 16'h00A5** → digits 3 and 2 are dark (seg=7'h7F), digits 1 and 0 show A and 5. Load 16'h0000 → only digit 0 shows '0'.
- **Assert reset while pending=1 and idx=2** → an is inactive immediately, pending=0, and after release the display shows 0000.

Source files
------------

// File: rtl/hexdisp_pkg.sv
// Shared constants and helpers for the hex display driver and its siblings.
package hexdisp_pkg;

  // Active-high gfedcba patterns for hex digits 0..F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

  // Width of the digit index; at least one bit even for a single digit.
  function automatic int idx_w(input int digits);
    return $clog2(digits > 1 ? digits : 2);
  endfunction

endpackage

// File: rtl/hexdisp_prescaler.sv
// Free-running divider: tick is high for one cycle every CLK_DIV clocks.
module hexdisp_prescaler #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CW'(CLK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hexdisp_mux.sv
// Time-multiplexed, double-buffered hex display driver.
// Define HEXDISP_LZB_EN to enable leading-zero blanking.
module hexdisp_mux
  import hexdisp_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank,
  input  logic                load,
  output logic                pending,
  output logic                frame,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an
);

  localparam int   IW  = idx_w(DIGITS);
  localparam int   VW  = 4 * DIGITS;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic tick, wrap;

  logic [VW-1:0]     sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0] sh_blk_q, sh_blk_d, act_blk_q, act_blk_d;
  logic              pending_q, pending_d;
  logic              frame_q;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic [DIGITS-1:0] lzb_mask;
  logic [3:0]        cur_nib;
  logic              cur_dp, cur_off;

  hexdisp_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign wrap = tick && (idx_q == IW'(DIGITS - 1));

  // A load coinciding with the wrap bypasses the shadow straight into active.
  always_comb begin
    sh_val_d  = load ? value : sh_val_q;
    sh_dp_d   = load ? dp_in : sh_dp_q;
    sh_blk_d  = load ? blank : sh_blk_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    act_blk_d = act_blk_q;
    pending_d = pending_q | load;
    idx_d     = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
    if (wrap) begin
      pending_d = 1'b0;
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp_in;
        act_blk_d = blank;
      end else if (pending_q) begin
        act_val_d = sh_val_q;
        act_dp_d  = sh_dp_q;
        act_blk_d = sh_blk_q;
      end
    end
  end

`ifdef HEXDISP_LZB_EN
  always_comb begin : lzb_calc
    logic run;
    lzb_mask = '0;
    run      = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run         = run & (act_val_q[4*i +: 4] == 4'h0);
      lzb_mask[i] = run & ~act_dp_q[i];
    end
  end
`else
  assign lzb_mask = '0;
`endif

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_off = 1'b0;
    an_d    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib = act_val_q[4*i +: 4];
        cur_dp  = act_dp_q[i];
        cur_off = act_blk_q[i] | lzb_mask[i];
        an_d[i] = ~tick;
      end
    end
    seg_d = (cur_off ? 7'h00 : seg_decode(cur_nib)) ^ {7{POL}};
    dp_d  = (cur_dp & ~cur_off) ^ POL;
    an_d  = an_d ^ {DIGITS{POL}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      sh_blk_q  <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_blk_q <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      idx_q     <= '0;
      seg_q     <= {7{POL}};
      dp_q      <= POL;
      an_q      <= {DIGITS{POL}};
    end else begin
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      sh_blk_q  <= sh_blk_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      act_blk_q <= act_blk_d;
      pending_q <= pending_d;
      frame_q   <= wrap;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign pending = pending_q;
  assign frame   = frame_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;

endmodule
